mac_rx_ctrl: RTL and testbench

MAC_RX_CTRL -- requirements
Module: mac_rx_ctrl

---
 rtl/mac_rx_ctrl.sv | 98 +++++++++
 tb/tb_mac_rx_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mac_rx_ctrl.sv
// mac_rx_ctrl: GMII receive front end that strips the preamble, filters on destination MAC and EtherType, and streams payload to a protocol demux
//   clk, rst_n       : receive clock, synchronous active-low reset
//   gmii_rxdv/rxd    : PHY receive valid and byte
//   mode             : EtherType of the accepted frame (0800/0806), 0000 when idle
//   fs_mode/fd_mode  : frame-start to the demux / frame-done back from it
//   rxd              : payload bytes, one cycle behind gmii_rxd
//   src_mac          : source MAC of the last accepted frame
//   err              : one-cycle pulse on framing error or timeout
module mac_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR = 48'h00_0A_35_01_FE_C0,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  output logic [15:0] mode,
  output logic        fs_mode,
  input  logic        fd_mode,
  output logic [7:0]  rxd,
  output logic [47:0] src_mac,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, PREAM, HEAD, WORK, REST, DROP} state_t;
  state_t state, state_n;
  logic [2:0]   pre_cnt;
  logic [3:0]   hdr_cnt;
  logic [103:0] hdr;
  logic [15:0]  to_cnt;
  logic [111:0] hdr_full;
  logic         hit, err_n, clr_mode;
  // hdr_full includes the byte being sampled, so the decision on header byte 13 uses the complete header
  assign hdr_full = {hdr, gmii_rxd};
  assign hit = (hdr_full[111:64] == MAC_ADDR || &hdr_full[111:64]) &&
               (hdr_full[15:0] == 16'h0800 || hdr_full[15:0] == 16'h0806);
  assign fs_mode = state == WORK;
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    clr_mode = 1'b0;
    case (state)
      IDLE: if (gmii_rxdv && gmii_rxd == 8'h55) state_n = PREAM;
      PREAM:
        if (gmii_rxdv && gmii_rxd == 8'hD5) state_n = HEAD;
        else if (!gmii_rxdv || gmii_rxd != 8'h55 || pre_cnt == 3'd7) begin
          state_n = IDLE;
          err_n = 1'b1;
        end
      HEAD:
        if (!gmii_rxdv) begin
          state_n = IDLE;
          err_n = 1'b1;
        end else if (hdr_cnt == 4'd13) state_n = hit ? WORK : DROP;
      WORK:
        if (fd_mode) state_n = REST;
        else if (!gmii_rxdv && to_cnt == TIMEOUT - 16'd1) begin
          state_n = IDLE;
          err_n = 1'b1;
          clr_mode = 1'b1;
        end
      REST:
        if (!gmii_rxdv) begin
          state_n = IDLE;
          clr_mode = 1'b1;
        end
      DROP: if (!gmii_rxdv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 3'd0;
      hdr_cnt <= 4'd0;
      hdr <= '0;
      to_cnt <= 16'd0;
      rxd <= 8'h00;
      mode <= 16'h0000;
      src_mac <= 48'h0;
      err <= 1'b0;
    end else begin
      err <= err_n;
      pre_cnt <= state_n == PREAM ? pre_cnt + 3'd1 : 3'd0;
      hdr_cnt <= (state == HEAD && state_n == HEAD) ? hdr_cnt + 4'd1 : 4'd0;
      hdr <= state == HEAD ? hdr_full[103:0] : hdr;
      // timeout counter runs only while WORK sees gmii_rxdv low; any valid byte restarts it
      to_cnt <= (state == WORK && state_n == WORK && !gmii_rxdv) ? to_cnt + 16'd1 : 16'd0;
      rxd <= (state == WORK && gmii_rxdv) ? gmii_rxd : 8'h00;
      if (state == HEAD && state_n == WORK) begin
        mode <= hdr_full[15:0];
        src_mac <= hdr_full[63:16];
      end else if (clr_mode) mode <= 16'h0000;
    end
  end
endmodule

// File: tb/tb_mac_rx_ctrl.sv
// tb_mac_rx_ctrl: frame-level vector table plus directed corner-case sequences for mac_rx_ctrl
module tb_mac_rx_ctrl;
  localparam logic [47:0] MAC = 48'h000A3501FEC0;
  localparam logic [47:0] BC = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] TO = 16'd20;
  logic clk = 1'b0, rst_n = 1'b0, gmii_rxdv = 1'b0, fd_mode = 1'b0;
  logic [7:0] gmii_rxd = 8'h00;
  logic [15:0] mode;
  logic fs_mode, err;
  logic [7:0] rxd;
  logic [47:0] src_mac;
  logic [47:0] exp_src = 48'h0;
  int checks = 0, passed = 0;
  typedef struct {
    int          npre;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    int          np;
    logic        acc;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  mac_rx_ctrl #(.MAC_ADDR(MAC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxdv(gmii_rxdv), .gmii_rxd(gmii_rxd),
    .mode(mode), .fs_mode(fs_mode), .fd_mode(fd_mode), .rxd(rxd),
    .src_mac(src_mac), .err(err)
  );
  function automatic logic [7:0] pay(input int k);
    return 8'(k * 37 + 90);
  endfunction
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask
  task automatic chk_reset();
    chk("rst_mode", 48'(mode), 48'h0);
    chk("rst_fs", 48'(fs_mode), 48'h0);
    chk("rst_err", 48'(err), 48'h0);
    chk("rst_rxd", 48'(rxd), 48'h0);
    chk("rst_src", src_mac, 48'h0);
  endtask
  // inputs are driven and outputs checked on the falling edge; outputs seen at negedge j come from posedge j-1
  task automatic run_frame(input vec_t v);
    logic [111:0] h;
    int p, last;
    h = {v.dst, v.src, v.et};
    p = v.npre + 15;
    last = p + v.np - 1;
    for (int j = 0; j <= last + 3; j++) begin
      @(negedge clk);
      if (j > 0) begin
        chk("err", 48'(err), 48'h0);
        chk("fs_mode", 48'(fs_mode), 48'(v.acc && j >= p && j <= last + 1));
        chk("mode", 48'(mode), (v.acc && j >= p && j <= last + 2) ? 48'(v.et) : 48'h0);
        chk("rxd", 48'(rxd), (v.acc && j - 1 >= p && j - 1 <= last) ? 48'(pay(j - 1 - p)) : 48'h0);
      end
      gmii_rxdv = j <= last;
      fd_mode = j == last + 1;
      gmii_rxd = j < v.npre ? 8'h55 : j == v.npre ? 8'hD5 : j < p ? h[8 * (p - 1 - j) +: 8] :
                 j <= last ? pay(j - p) : 8'h00;
    end
    if (v.acc) exp_src = v.src;
    chk("src_mac", src_mac, exp_src);
  endtask
  task automatic start_work(input logic [47:0] src, input int np);
    logic [111:0] h;
    h = {MAC, src, 16'h0800};
    for (int j = 0; j < 22 + np; j++) begin
      @(negedge clk);
      gmii_rxdv = 1'b1;
      gmii_rxd = j < 7 ? 8'h55 : j == 7 ? 8'hD5 : j < 22 ? h[8 * (21 - j) +: 8] : pay(j - 22);
    end
  endtask
  initial begin
    tbl[0] = '{7, MAC, 48'h112233445566, 16'h0800, 46, 1'b1};
    tbl[1] = '{7, BC, 48'hA1A2A3A4A5A6, 16'h0806, 28, 1'b1};
    tbl[2] = '{7, 48'h020000000001, 48'h0A0B0C0D0E0F, 16'h0806, 28, 1'b0};
    tbl[3] = '{7, MAC, 48'h102030405060, 16'h86DD, 10, 1'b0};
    tbl[4] = '{1, MAC, 48'hCAFE00000001, 16'h0806, 1, 1'b1};
    tbl[5] = '{7, BC, 48'h123456789ABC, 16'h0801, 5, 1'b0};
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      gmii_rxdv = 1'b1;
      gmii_rxd = k == 2 ? 8'hAA : 8'h55;
    end
    @(negedge clk);
    chk("bad_pre_err", 48'(err), 48'h1);
    gmii_rxdv = 1'b0;
    @(negedge clk);
    chk("bad_pre_err_end", 48'(err), 48'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 8) chk("long_pre_err", 48'(err), 48'h1);
      gmii_rxdv = 1'b1;
      gmii_rxd = k == 8 ? 8'hD5 : 8'h55;
    end
    @(negedge clk);
    chk("long_pre_err_end", 48'(err), 48'h0);
    chk("long_pre_fs", 48'(fs_mode), 48'h0);
    gmii_rxdv = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      gmii_rxdv = j < 13;
      gmii_rxd = j < 7 ? 8'h55 : j == 7 ? 8'hD5 : MAC[8 * (12 - j) +: 8];
    end
    @(negedge clk);
    chk("hdr_cut_err", 48'(err), 48'h1);
    chk("hdr_cut_mode", 48'(mode), 48'h0);
    chk("hdr_cut_src", src_mac, exp_src);
    @(negedge clk);
    chk("hdr_cut_err_end", 48'(err), 48'h0);
    start_work(48'h5A5A00001111, 2);
    exp_src = 48'h5A5A00001111;
    @(negedge clk);
    gmii_rxdv = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      chk("to_err", 48'(err), 48'(k == int'(TO)));
      chk("to_fs", 48'(fs_mode), 48'(k != int'(TO)));
      if (k == int'(TO)) chk("to_mode", 48'(mode), 48'h0);
    end
    @(negedge clk);
    chk("to_err_end", 48'(err), 48'h0);
    chk("to_src", src_mac, exp_src);
    start_work(48'h665544332211, 3);
    @(negedge clk);
    chk("pre_rst_fs", 48'(fs_mode), 48'h1);
    chk("pre_rst_rxd", 48'(rxd), 48'(pay(2)));
    chk("pre_rst_mode", 48'(mode), 48'h0800);
    chk("pre_rst_src", src_mac, 48'h665544332211);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    exp_src = 48'h0;
    rst_n = 1'b1;
    gmii_rxdv = 1'b0;
    @(negedge clk);
    run_frame(tbl[0]);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
